// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold handling
// and a saturating load-use stall counter.
// Optional build macro: ID_EX_WB_BYPASS_EN -- when defined, operand data being
// captured takes the writeback value if writeback targets the same register in
// the same cycle (register-file write/read collision). When undefined the wb_*
// ports are present but ignored.
module id_ex_stage_reg #(
   parameter int BUS_DATA_WIDTH  = 64,
   parameter int ALUOP_WIDTH     = 5,
   parameter int STALL_CNT_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       ex_hold,
   input  logic                       id_valid,
   input  logic [4:0]                 id_rs1,
   input  logic [4:0]                 id_rs2,
   input  logic [4:0]                 id_rd,
   input  logic                       id_reg_write,
   input  logic                       id_mem_read,
   input  logic                       id_mem_write,
   input  logic [ALUOP_WIDTH-1:0]     id_alu_op,
   input  logic [BUS_DATA_WIDTH-1:0]  id_rs1_data,
   input  logic [BUS_DATA_WIDTH-1:0]  id_rs2_data,
   input  logic [BUS_DATA_WIDTH-1:0]  id_imm,
   input  logic [BUS_DATA_WIDTH-1:0]  id_pc,
   input  logic                       wb_reg_write,
   input  logic [4:0]                 wb_rd,
   input  logic [BUS_DATA_WIDTH-1:0]  wb_data,
   output logic                       id_stall,
   output logic                       ex_valid,
   output logic [4:0]                 ex_rs1,
   output logic [4:0]                 ex_rs2,
   output logic [4:0]                 ex_rd,
   output logic                       ex_reg_write,
   output logic                       ex_mem_read,
   output logic                       ex_mem_write,
   output logic [ALUOP_WIDTH-1:0]     ex_alu_op,
   output logic [BUS_DATA_WIDTH-1:0]  ex_rs1_data,
   output logic [BUS_DATA_WIDTH-1:0]  ex_rs2_data,
   output logic [BUS_DATA_WIDTH-1:0]  ex_imm,
   output logic [BUS_DATA_WIDTH-1:0]  ex_pc,
   output logic [STALL_CNT_WIDTH-1:0] load_use_stalls
);

   // Saturating increment: the stall counter sticks at all-ones.
   function automatic logic [STALL_CNT_WIDTH-1:0] sat_inc(
      input logic [STALL_CNT_WIDTH-1:0] v
   );
      if (&v)
         return v;
      else
         return v + {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
   endfunction

   logic                      hazard;
   logic                      count_stall;
   logic [BUS_DATA_WIDTH-1:0] rs1_data_cap;
   logic [BUS_DATA_WIDTH-1:0] rs2_data_cap;

   // A load in EX whose (non-zero) destination is read by the decode
   // instruction cannot be forwarded in time; decode must wait one cycle.
   assign hazard = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                   ((ex_rd == id_rs1) | (ex_rd == id_rs2));

   // A flush discards the decode instruction, so there is nothing to hold.
   assign id_stall = !flush & (ex_hold | hazard);

   // Stalls are counted only on edges where the bubble is actually inserted.
   assign count_stall = hazard & !flush & !ex_hold;

`ifdef ID_EX_WB_BYPASS_EN
   // Writeback lands in the register file on the same edge decode reads it,
   // so steer the in-flight writeback value into the captured operands.
   always_comb begin
      rs1_data_cap = id_rs1_data;
      rs2_data_cap = id_rs2_data;
      if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs1))
         rs1_data_cap = wb_data;
      if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs2))
         rs2_data_cap = wb_data;
   end
`else
   logic unused_wb;
   assign unused_wb    = ^{wb_reg_write, wb_rd, wb_data};
   assign rs1_data_cap = id_rs1_data;
   assign rs2_data_cap = id_rs2_data;
`endif

   // ---- ID -> EX stage boundary ----
   // Priority: reset, flush bubble, hold, hazard bubble, empty-decode bubble,
   // capture. Bubbles zero every field so ex_rd/ex_rs* never match forwarding.
   always_ff @(posedge clk) begin
      if (reset || flush || (!ex_hold && (hazard || !id_valid))) begin
         ex_valid     <= 1'b0;
         ex_rs1       <= '0;
         ex_rs2       <= '0;
         ex_rd        <= '0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_alu_op    <= '0;
         ex_rs1_data  <= '0;
         ex_rs2_data  <= '0;
         ex_imm       <= '0;
         ex_pc        <= '0;
      end else if (!ex_hold) begin
         ex_valid     <= 1'b1;
         ex_rs1       <= id_rs1;
         ex_rs2       <= id_rs2;
         ex_rd        <= id_rd;
         ex_reg_write <= id_reg_write;
         ex_mem_read  <= id_mem_read;
         ex_mem_write <= id_mem_write;
         ex_alu_op    <= id_alu_op;
         ex_rs1_data  <= rs1_data_cap;
         ex_rs2_data  <= rs2_data_cap;
         ex_imm       <= id_imm;
         ex_pc        <= id_pc;
      end
   end

   // Load-use stall counter, saturating.
   always_ff @(posedge clk) begin
      if (reset)
         load_use_stalls <= '0;
      else if (count_stall)
         load_use_stalls <= sat_inc(load_use_stalls);
   end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg. The stall counter is narrowed to 3 bits
// so that saturation is reachable with a short stimulus sequence.
module tb_id_ex_stage_reg;

   localparam int DW = 64;
   localparam int AW = 5;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          reset, flush, ex_hold, id_valid;
   logic [4:0]    id_rs1, id_rs2, id_rd;
   logic          id_reg_write, id_mem_read, id_mem_write;
   logic [AW-1:0] id_alu_op;
   logic [DW-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
   logic          wb_reg_write;
   logic [4:0]    wb_rd;
   logic [DW-1:0] wb_data;
   logic          id_stall, ex_valid;
   logic [4:0]    ex_rs1, ex_rs2, ex_rd;
   logic          ex_reg_write, ex_mem_read, ex_mem_write;
   logic [AW-1:0] ex_alu_op;
   logic [DW-1:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
   logic [CW-1:0] load_use_stalls;

   int tests = 0;
   int fails = 0;

   id_ex_stage_reg #(.BUS_DATA_WIDTH(DW), .ALUOP_WIDTH(AW), .STALL_CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .flush(flush), .ex_hold(ex_hold), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_alu_op(id_alu_op), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_pc(id_pc),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .id_stall(id_stall), .ex_valid(ex_valid),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_alu_op(ex_alu_op), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
      .ex_imm(ex_imm), .ex_pc(ex_pc), .load_use_stalls(load_use_stalls)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_id();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_alu_op = 0;
      id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_pc = 0;
   endtask

   task automatic present_load(input logic [4:0] rd);
      idle_id();
      id_valid = 1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = rd;
      id_mem_read = 1; id_reg_write = 1; id_pc = 64'h100; id_imm = 64'h8;
   endtask

   task automatic present_use(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
      idle_id();
      id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_reg_write = 1; id_alu_op = 5'd5; id_rs2_data = 64'h22; id_pc = 64'h104;
   endtask

   // Load followed by a dependent instruction: exactly one bubble.
   task automatic load_use_cycle();
      present_load(5'd3); step();
      present_use(5'd9, 5'd3, 5'd6); #1;
      chk("lu_stall", id_stall, 1);
      step();
      chk("lu_bubble", ex_valid, 0);
      step();
      chk("lu_capture", ex_valid, 1);
   endtask

   initial begin
      reset = 1; flush = 0; ex_hold = 0;
      wb_reg_write = 0; wb_rd = 0; wb_data = 0;
      idle_id();
      step();
      chk("rst_valid", ex_valid, 0);
      chk("rst_rd", ex_rd, 0);
      chk("rst_cnt", load_use_stalls, 0);
      reset = 0;

      // Counter to 5 with a live instruction in EX, then reset.
      for (int i = 0; i < 5; i++) load_use_cycle();
      chk("pre_rst_cnt", load_use_stalls, 5);
      chk("pre_rst_valid", ex_valid, 1);
      present_load(5'd3);
      reset = 1; step(); reset = 0;
      chk("mid_rst_valid", ex_valid, 0);
      chk("mid_rst_memrd", ex_mem_read, 0);
      chk("mid_rst_pc", ex_pc, 0);
      chk("mid_rst_cnt", load_use_stalls, 0);

      // Detailed load-use.
      present_load(5'd3); step();
      chk("ld_lat_valid", ex_valid, 1);
      chk("ld_lat_rd", ex_rd, 3);
      chk("ld_lat_memrd", ex_mem_read, 1);
      chk("ld_lat_pc", ex_pc, 64'h100);
      present_use(5'd9, 5'd3, 5'd6); #1;
      chk("hz_stall", id_stall, 1);
      step();
      chk("hz_bub_valid", ex_valid, 0);
      chk("hz_bub_rd", ex_rd, 0);
      chk("hz_bub_rs2", ex_rs2, 0);
      chk("hz_bub_memrd", ex_mem_read, 0);
      chk("hz_after_stall", id_stall, 0);
      chk("hz_cnt", load_use_stalls, 1);
      step();
      chk("hz_cap_valid", ex_valid, 1);
      chk("hz_cap_rs2", ex_rs2, 3);
      chk("hz_cap_rd", ex_rd, 6);
      chk("hz_cap_alu", ex_alu_op, 5);
      chk("hz_cap_rs2d", ex_rs2_data, 64'h22);
      chk("hz_cap_cnt", load_use_stalls, 1);

      // Flush on the hazard cycle.
      present_load(5'd3); step();
      present_use(5'd3, 5'd8, 5'd6);
      flush = 1; #1;
      chk("fl_stall", id_stall, 0);
      step();
      flush = 0;
      chk("fl_bub_valid", ex_valid, 0);
      chk("fl_cnt", load_use_stalls, 1);
      step();
      chk("fl_next_valid", ex_valid, 1);

      // Hold for 3 cycles with a new instruction waiting.
      present_use(5'd10, 5'd11, 5'd7);
      ex_hold = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold_stall", id_stall, 1);
         step();
         chk("hold_rd", ex_rd, 6);
         chk("hold_valid", ex_valid, 1);
      end
      ex_hold = 0;
      step();
      chk("hold_rel_rd", ex_rd, 7);

      // Hold together with a load-use hazard: no bubble, no count.
      present_load(5'd3); step();
      present_use(5'd3, 5'd0, 5'd6);
      ex_hold = 1; #1;
      chk("hh_stall", id_stall, 1);
      step();
      chk("hh_rd", ex_rd, 3);
      chk("hh_valid", ex_valid, 1);
      chk("hh_cnt", load_use_stalls, 1);
      ex_hold = 0; #1;
      chk("hh_rel_stall", id_stall, 1);
      step();
      chk("hh_rel_bub", ex_valid, 0);
      chk("hh_rel_cnt", load_use_stalls, 2);
      step();

      // Load to x0 never stalls; dependent two slots behind a load never stalls.
      present_load(5'd0); step();
      present_use(5'd0, 5'd0, 5'd6); #1;
      chk("x0_stall", id_stall, 0);
      step();
      chk("x0_valid", ex_valid, 1);
      present_load(5'd3); step();
      present_use(5'd8, 5'd9, 5'd6); #1;
      chk("gap_indep_stall", id_stall, 0);
      step();
      present_use(5'd3, 5'd9, 5'd6); #1;
      chk("gap_dep_stall", id_stall, 0);
      step();
      chk("gap_cnt", load_use_stalls, 2);

      // Saturation of the 3-bit counter.
      for (int i = 0; i < 5; i++) load_use_cycle();
      chk("sat_full", load_use_stalls, 7);
      load_use_cycle();
      chk("sat_hold", load_use_stalls, 7);

      // Writeback collision on rs1 only.
      idle_id();
      id_valid = 1; id_rs1 = 5'd4; id_rs2 = 5'd5; id_rd = 5'd6;
      id_rs1_data = 64'h11; id_rs2_data = 64'h33;
      wb_reg_write = 1; wb_rd = 5'd4; wb_data = 64'hAA;
      step();
`ifdef ID_EX_WB_BYPASS_EN
      chk("wb_rs1", ex_rs1_data, 64'hAA);
`else
      chk("wb_rs1", ex_rs1_data, 64'h11);
`endif
      chk("wb_rs2", ex_rs2_data, 64'h33);
      wb_reg_write = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Decode/execute pipeline register. Sits directly upstream of the EX-stage forwarding unit.
- Supplies the forwarding unit with the EX-stage source register numbers (ex_rs1/ex_rs2), and supplies operands/control to the ALU.
- Contains load-use hazard detection: stalls decode for exactly one cycle and injects a bubble into EX.
- Handles pipeline flush and downstream hold, and counts load-use stalls.

Parameters:
- BUS_DATA_WIDTH, 64, width of operand, immediate and PC fields
- ALUOP_WIDTH, 5, width of ALU operation code
- STALL_CNT_WIDTH, 32, width of load-use stall counter

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  kill the instruction being captured this cycle (branch redirect)
- ex_hold  in  1  EX cannot accept; freeze register
- id_valid  in  1  decode presents an instruction
- id_rs1, id_rs2, id_rd  in  5 each  decode register numbers
- id_reg_write, id_mem_read, id_mem_write  in  1 each  decode control bits
- id_alu_op  in  ALUOP_WIDTH  ALU operation
- id_rs1_data, id_rs2_data, id_imm, id_pc  in  BUS_DATA_WIDTH each  decode operands
- wb_reg_write  in  1  writeback writes register file this cycle
- wb_rd  in  5  writeback destination
- wb_data  in  BUS_DATA_WIDTH  writeback value
- id_stall  out  1  combinational; decode/fetch must hold their current instruction
- ex_valid  out  1  EX slot holds a real instruction
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered register numbers
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered control bits
- ex_alu_op  out  ALUOP_WIDTH  registered ALU operation
- ex_rs1_data, ex_rs2_data, ex_imm, ex_pc  out  BUS_DATA_WIDTH each  registered operands
- load_use_stalls  out  STALL_CNT_WIDTH  saturating load-use stall count

Behaviour:
- Reset values: every ex_* output is 0, and load_use_stalls is 0. Reset overrides all other inputs, including mid-stall.
- hazard (combinational) = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
- id_stall = !flush & (ex_hold | hazard).
- Register update priority at each clk edge:
  1. reset.
  2. flush: load a bubble.
  3. ex_hold: all ex_* keep their values.
  4. hazard: load a bubble.
  5. id_valid = 0: load a bubble.
  6. Otherwise: capture all id_* fields, and set ex_valid = 1.
- Bubble: ex_valid = 0, and every other ex_* field = 0. Because ex_rd, ex_rs1 and ex_rs2 are 0, downstream forwarding never matches a bubble.
- Load-use stall length is exactly 1 cycle. On the cycle after the bubble, ex_mem_read = 0, hazard drops, and the held decode instruction is captured.
- Back-to-back loads with a dependency each stall 1 cycle. A dependent instruction two slots behind a load does not stall (it is handled by forwarding).
- ex_hold and hazard together: the register holds (no bubble) and id_stall = 1. hazard is re-evaluated after the hold releases.
- flush and hazard together: flush wins, a bubble is loaded, id_stall = 0, and the counter is not incremented.
- load_use_stalls increments by 1 on each edge where hazard & !flush & !ex_hold. It saturates at all-ones and never wraps.
- Register 0: id_rs fields equal to 0 never produce a hazard. ex_rd = 0 is never treated as a producer.
- Latency: decode to EX outputs is 1 cycle when there is no stall.

Optional Feature:
- Macro: ID_EX_WB_BYPASS_EN.
- With the macro defined: on capture (priority case 6), if wb_reg_write & (wb_rd != 0) & (wb_rd == id_rs1), then ex_rs1_data takes wb_data instead of id_rs1_data. The same rule applies independently to rs2. This covers register-file write/read in the same cycle.
- Without the macro: wb_* ports remain present but are ignored, and operand data is captured from id_* only.
- The macro does not change the hazard, stall or counter behaviour.

Test Plan:
- Reset while ex_valid = 1 and the counter is 5: next edge, all ex_* = 0 and load_use_stalls = 0.
- EX holds a load (ex_mem_read = 1, ex_rd = 3); decode has id_rs2 = 3, id_valid = 1:
  - id_stall = 1 and the next cycle is a bubble (ex_valid = 0, ex_rd = 0).
  - The following cycle captures the instruction with ex_rs2 = 3.
  - load_use_stalls = 1.
- Same load-use setup with flush = 1 on the hazard cycle: id_stall = 0, a bubble is loaded, and the counter is unchanged.
- ex_hold = 1 for 3 cycles while id_valid = 1 and id_rd = 7:
  - ex_* are frozen and id_stall = 1 throughout.
  - On release, ex_rd = 7 one cycle later.
- Load with ex_rd = 0 and id_rs1 = 0: no stall. Counter preset to all-ones plus a real hazard: counter stays all-ones.
- With ID_EX_WB_BYPASS_EN: wb_reg_write = 1, wb_rd = 4, wb_data = 0xAA, id_rs1 = 4, id_rs1_data = 0x11 gives ex_rs1_data = 0xAA. Without the macro, ex_rs1_data = 0x11.
